sync_fifo_ext: RTL and testbench
================================

Name: sync_fifo_ext

Overview:
Single-clock, parametrised FIFO for intra-domain buffering in the SDR datapath, e.g. between the DDC output and the packetiser. It succeeds the dual-clock FIFO for same-domain paths and adds several features:
- selectable standard or first-word-fall-through (FWFT) read mode;
- exact fill level;
- programmable almost-full/almost-empty thresholds;
- synchronous flush;
- sticky overflow/underflow error flags.

Storage is a registered-read dual-port RAM, so it maps to block RAM.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 256, capacity in words; power of two, >=4
FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through
AW, $clog2(DEPTH), derived localparam; not overridable

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active low
clr  in  1  synchronous flush; empties FIFO
din  in  WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
dout  out  WIDTH  read data
valid  out  1  dout holds a word (standard: 1-cycle pulse; FWFT: level)
full  out  1  level == DEPTH
empty  out  1  standard: level == 0; FWFT: !valid
almost_full  out  1  level >= af_thresh
almost_empty  out  1  level <= ae_thresh
af_thresh  in  AW+1  almost-full threshold, quasi-static
ae_thresh  in  AW+1  almost-empty threshold, quasi-static
level  out  AW+1  words written and not yet popped, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset values (rst_n low, asynchronous):
  - pointers 0, level 0, dout 0, valid 0, full 0, empty 1, overflow 0, underflow 0;
  - almost_full and almost_empty follow their threshold compares on level = 0.
- Pointers are AW+1-bit binary; the MSB distinguishes full from empty; the RAM is addressed by [AW-1:0]; wrap-around is natural modulo 2^(AW+1).
- Write accept: wr_en && !full.
  - The accepted word is stored at the next edge and the write pointer increments.
  - Writes while full are dropped, RAM and pointers are unchanged, and overflow sets.
  - A simultaneous read does not free a slot in the same cycle: a write while full is rejected even if rd_en is high.
- Standard mode (FWFT=0):
  - Read accept: rd_en && !empty.
  - The word is presented on dout with valid=1 in the cycle after the accepting edge.
  - dout holds its last value otherwise; valid is low otherwise.
  - rd_en while empty: underflow sets and nothing changes.
  - Simultaneous write and read at level 0: the read is rejected (underflow) and the write is accepted.
- FWFT mode (FWFT=1):
  - An internal prefetch stage keeps the head word on dout whenever level > 0.
  - A write accepted into an empty FIFO at edge k gives valid=1 after edge k+2.
  - rd_en && valid pops the head word. If more words are stored, the next word appears with valid held high continuously (back-to-back pops at 1 word/cycle).
  - rd_en with valid=0 sets underflow.
  - The prefetch stage counts toward level; total capacity is exactly DEPTH.
- level:
  - +1 on an accepted write only, -1 on an accepted read/pop only, unchanged when both are accepted.
  - Registered; full, empty, almost_full and almost_empty are derived from registered state with no extra latency.
- Thresholds: af_thresh = 0 forces almost_full = 1; ae_thresh >= DEPTH forces almost_empty = 1. Both are compared unsigned.
- clr (synchronous, highest priority over wr_en/rd_en in the same cycle):
  - pointers, level, valid and dout return to reset values;
  - overflow/underflow are not affected;
  - wr_en/rd_en in a clr cycle are ignored and do not set error flags.
- err_clr clears both sticky flags at the next edge. If a new error occurs in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately; RAM contents are don't-care.

Decomposition:
- Shared package fifo_pkg:
  - function clog2-safe width helper;
  - FIFO_MODE_STD = 0 / FIFO_MODE_FWFT = 1 constants;
  - level-width helper.
- Sub-module fifo_sdp_ram (WIDTH, DEPTH): simple dual-port RAM with a synchronous write port and a registered read port with read-enable.
- Pointer, level and prefetch logic stay in sync_fifo_ext.

Test Plan:
- DEPTH=8, FWFT=0: write 0x11..0x88 on 8 consecutive cycles -> full=1 after the 8th edge, level=8, almost_full=1 with af_thresh=6. Then read 8 -> dout 0x11..0x88, each valid the cycle after rd_en; empty=1, level=0.
- DEPTH=8, FWFT=1: single write 0xA5 at edge k -> valid=1 and dout=0xA5 after edge k+2. Then write 0x01..0x07 and pop continuously -> one word per cycle, valid never drops until level=0.
- Full with simultaneous rd_en+wr_en (din=0xDEAD) -> write dropped, overflow=1, level=7 after the edge. Read all -> 0xDEAD never appears.
- Empty with rd_en -> underflow=1, level stays 0. err_clr pulse -> underflow=0. err_clr together with a new underflow -> underflow stays 1.
- Wrap: 3*DEPTH+3 writes/reads interleaved with random stalls -> data order preserved across pointer wrap, level matches the scoreboard every cycle.
- level=5, then clr with wr_en=1 -> level=0, empty=1, valid=0, dout=0, overflow unchanged. Separately, assert rst_n mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address width that never collapses to zero for tiny depths.
    function automatic int fifo_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Pointer/level width: one extra bit so that full and empty differ.
    function automatic int fifo_lw(input int depth);
        return fifo_aw(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 256,
    localparam int AW    = fifo_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // No reset on the read register so the whole structure maps onto block RAM.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read, exact level,
// programmable almost flags, synchronous flush and sticky error flags.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 256,
    parameter  int FWFT  = FIFO_MODE_STD,
    localparam int AW    = fifo_aw(DEPTH),
    localparam int LW    = fifo_lw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    input  logic [LW-1:0]    af_thresh,
    input  logic [LW-1:0]    ae_thresh,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_acc;
    logic             pop;      // a word leaves the FIFO (counts against level)
    logic             rd_err;
    logic             ram_re;   // RAM read issued (advances the read pointer)
    logic [WIDTH-1:0] ram_rdata;

    assign full         = (level_q == DEPTH_L);
    assign wr_acc       = wr_en && !full && !clr;
    assign almost_full  = (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    fifo_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (din),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ONE_L;
            end
            if (ram_re) begin
                rd_ptr_d = rd_ptr_q + ONE_L;
            end
            case ({wr_acc, pop})
                2'b10:   level_d = level_q + ONE_L;
                2'b01:   level_d = level_q - ONE_L;
                default: level_d = level_q;
            endcase
        end
        // A fresh error in the same cycle as err_clr must survive.
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_en && full && !clr) begin
            ovf_d = 1'b1;
        end
        if (rd_err) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Two-stage prefetch: RAM read register (mid) feeds the output register.
        logic             mid_valid_q, mid_valid_d;
        logic             out_valid_q, out_valid_d;
        logic [WIDTH-1:0] dout_q, dout_d;
        logic             ram_has_data;
        logic             out_load;
        logic             mid_take;

        assign ram_has_data = (wr_ptr_q != rd_ptr_q);
        assign pop          = rd_en && out_valid_q && !clr;
        assign rd_err       = rd_en && !out_valid_q && !clr;
        assign out_load     = !out_valid_q || pop;
        assign mid_take     = out_load && mid_valid_q;
        assign ram_re       = ram_has_data && (!mid_valid_q || mid_take) && !clr;

        always_comb begin
            mid_valid_d = mid_valid_q;
            out_valid_d = out_valid_q;
            dout_d      = dout_q;
            if (clr) begin
                mid_valid_d = 1'b0;
                out_valid_d = 1'b0;
                dout_d      = '0;
            end else begin
                if (mid_take) begin
                    out_valid_d = 1'b1;
                    dout_d      = ram_rdata;
                end else if (pop) begin
                    out_valid_d = 1'b0;
                end
                if (ram_re) begin
                    mid_valid_d = 1'b1;
                end else if (mid_take) begin
                    mid_valid_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mid_valid_q <= 1'b0;
                out_valid_q <= 1'b0;
                dout_q      <= '0;
            end else begin
                mid_valid_q <= mid_valid_d;
                out_valid_q <= out_valid_d;
                dout_q      <= dout_d;
            end
        end

        assign valid = out_valid_q;
        assign empty = !out_valid_q;
        assign dout  = dout_q;
    end else begin : g_std
        logic valid_q, valid_d;
        logic dout_zero_q, dout_zero_d;

        assign pop    = rd_en && (level_q != '0) && !clr;
        assign rd_err = rd_en && (level_q == '0) && !clr;
        assign ram_re = pop;

        // dout is the RAM read register itself; a mask gives the zero value
        // after reset/flush without putting a reset on the block RAM output.
        always_comb begin
            valid_d     = pop;
            dout_zero_d = dout_zero_q;
            if (clr) begin
                dout_zero_d = 1'b1;
            end else if (pop) begin
                dout_zero_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q     <= 1'b0;
                dout_zero_q <= 1'b1;
            end else begin
                valid_q     <= valid_d;
                dout_zero_q <= dout_zero_d;
            end
        end

        assign valid = valid_q;
        assign empty = (level_q == '0);
        assign dout  = dout_zero_q ? '0 : ram_rdata;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: one standard-mode and one FWFT instance, DEPTH=8.
module tb_sync_fifo_ext;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int LW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          clr_s = 1'b0, wr_s = 1'b0, rd_s = 1'b0, ec_s = 1'b0;
    logic [W-1:0]  din_s = '0, dout_s;
    logic          valid_s, full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic [LW-1:0] aft_s = 4'd6, aet_s = 4'd1, lvl_s;

    logic          clr_f = 1'b0, wr_f = 1'b0, rd_f = 1'b0, ec_f = 1'b0;
    logic [W-1:0]  din_f = '0, dout_f;
    logic          valid_f, full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [LW-1:0] aft_f = 4'd6, aet_f = 4'd1, lvl_f;

    int n_checks = 0;
    int n_errors = 0;

    sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr_s), .din(din_s), .wr_en(wr_s), .rd_en(rd_s),
        .dout(dout_s), .valid(valid_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .af_thresh(aft_s), .ae_thresh(aet_s),
        .level(lvl_s), .overflow(ovf_s), .underflow(udf_s), .err_clr(ec_s)
    );

    sync_fifo_ext #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr_f), .din(din_f), .wr_en(wr_f), .rd_en(rd_f),
        .dout(dout_f), .valid(valid_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .af_thresh(aft_f), .ae_thresh(aet_f),
        .level(lvl_f), .overflow(ovf_f), .underflow(udf_f), .err_clr(ec_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    int           wn, rn, lvl_m;
    logic         wa, ra;

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_lvl",   lvl_s,   0);
        check("rst_empty", empty_s, 1);
        check("rst_full",  full_s,  0);
        check("rst_valid", valid_s, 0);
        check("rst_dout",  dout_s,  0);
        check("rst_ovf",   ovf_s,   0);
        check("rst_udf",   udf_s,   0);
        check("rst_ae",    ae_s,    1);
        check("rst_af",    af_s,    0);
        check("rst_f_valid", valid_f, 0);
        check("rst_f_empty", empty_f, 1);
        check("rst_f_dout",  dout_f,  0);
        rst_n = 1'b1;
        tick();

        // ---------------- standard: fill 0x11..0x88 ----------------
        for (int i = 0; i < 8; i++) begin
            din_s = W'((i + 1) * 17);
            wr_s  = 1'b1;
            tick();
            check("std_wr_lvl",  lvl_s,  i + 1);
            check("std_wr_full", full_s, (i == 7));
            check("std_wr_af",   af_s,   ((i + 1) >= 6));
        end
        wr_s = 1'b0;
        check("std_full_ae", ae_s, 0);
        aet_s = 4'd8;
        #1;
        check("std_ae_force", ae_s, 1);
        aet_s = 4'd1;

        // ---------------- standard: read back ----------------
        for (int i = 0; i < 8; i++) begin
            rd_s = 1'b1;
            tick();
            check("std_rd_valid", valid_s, 1);
            check("std_rd_dout",  dout_s,  (i + 1) * 17);
            check("std_rd_lvl",   lvl_s,   7 - i);
            $display("std read %0d data %h", i, dout_s);
        end
        rd_s = 1'b0;
        tick();
        check("std_idle_valid", valid_s, 0);
        check("std_idle_dout",  dout_s,  16'h0088);
        check("std_idle_empty", empty_s, 1);

        // ---------------- overflow with simultaneous read ----------------
        for (int i = 0; i < 8; i++) begin
            din_s = W'(i + 1);
            wr_s  = 1'b1;
            tick();
        end
        din_s = 16'hDEAD;
        rd_s  = 1'b1;
        tick();
        wr_s = 1'b0;
        check("ovf_lvl",   lvl_s,   7);
        check("ovf_flag",  ovf_s,   1);
        check("ovf_dout0", dout_s,  1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("ovf_valid", valid_s, 1);
            check("ovf_dout",  dout_s,  i + 1);
        end
        rd_s = 1'b0;
        tick();
        check("ovf_empty", empty_s, 1);
        check("ovf_lvl0",  lvl_s,   0);

        // ---------------- underflow / err_clr ----------------
        rd_s = 1'b1;
        tick();
        rd_s = 1'b0;
        check("udf_flag",  udf_s,   1);
        check("udf_lvl",   lvl_s,   0);
        check("udf_valid", valid_s, 0);
        ec_s = 1'b1;
        tick();
        ec_s = 1'b0;
        check("errclr_udf", udf_s, 0);
        check("errclr_ovf", ovf_s, 0);
        ec_s = 1'b1;
        rd_s = 1'b1;
        tick();
        ec_s = 1'b0;
        rd_s = 1'b0;
        check("udf_set_wins", udf_s, 1);
        ec_s = 1'b1;
        tick();
        ec_s = 1'b0;

        // ---------------- wrap with random stalls ----------------
        wn = 0; rn = 0; lvl_m = 0;
        for (int cyc = 0; cyc < 400 && rn < 3 * D + 3; cyc++) begin
            wr_s  = (wn < 3 * D + 3) && ($urandom_range(0, 2) != 0);
            din_s = W'(16'h0100 + wn);
            rd_s  = ($urandom_range(0, 2) != 0);
            wa    = wr_s && (lvl_m < D);
            ra    = rd_s && (lvl_m > 0);
            tick();
            if (wa) begin
                q.push_back(din_s);
                wn++;
            end
            if (ra) begin
                exp_d = q.pop_front();
                rn++;
            end
            lvl_m = lvl_m + int'(wa) - int'(ra);
            check("wrap_lvl",   lvl_s,   lvl_m);
            check("wrap_valid", valid_s, ra);
            if (ra) begin
                check("wrap_dout", dout_s, exp_d);
                $display("wrap read %0d data %h", rn, dout_s);
            end
        end
        wr_s = 1'b0;
        rd_s = 1'b0;
        check("wrap_count", rn, 3 * D + 3);
        ec_s = 1'b1;
        tick();
        ec_s = 1'b0;

        // ---------------- flush ----------------
        for (int i = 0; i < 8; i++) begin
            din_s = W'(16'h0030 + i);
            wr_s  = 1'b1;
            tick();
        end
        din_s = 16'hBEEF;
        tick();
        wr_s = 1'b0;
        rd_s = 1'b1;
        repeat (3) tick();
        rd_s = 1'b0;
        check("clr_pre_lvl",   lvl_s,   5);
        check("clr_pre_valid", valid_s, 1);
        check("clr_pre_dout",  dout_s,  16'h0032);
        check("clr_pre_ovf",   ovf_s,   1);
        clr_s = 1'b1;
        wr_s  = 1'b1;
        din_s = 16'h0077;
        tick();
        clr_s = 1'b0;
        wr_s  = 1'b0;
        check("clr_lvl",   lvl_s,   0);
        check("clr_empty", empty_s, 1);
        check("clr_valid", valid_s, 0);
        check("clr_dout",  dout_s,  0);
        check("clr_ovf",   ovf_s,   1);
        check("clr_full",  full_s,  0);
        tick();
        check("clr_wr_ignored", lvl_s, 0);

        // ---------------- reset mid-burst ----------------
        for (int i = 0; i < 3; i++) begin
            din_s = W'(16'h0040 + i);
            wr_s  = 1'b1;
            tick();
        end
        check("mid_pre_lvl", lvl_s, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_lvl",   lvl_s,   0);
        check("mid_rst_empty", empty_s, 1);
        check("mid_rst_valid", valid_s, 0);
        check("mid_rst_dout",  dout_s,  0);
        check("mid_rst_ovf",   ovf_s,   0);
        check("mid_rst_ae",    ae_s,    1);
        wr_s = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- FWFT: first-word latency ----------------
        din_f = 16'h00A5;
        wr_f  = 1'b1;
        tick();
        wr_f = 1'b0;
        check("fw_k_lvl",   lvl_f,   1);
        check("fw_k_valid", valid_f, 0);
        check("fw_k_empty", empty_f, 1);
        tick();
        check("fw_k1_valid", valid_f, 0);
        tick();
        check("fw_k2_valid", valid_f, 1);
        check("fw_k2_dout",  dout_f,  16'h00A5);
        check("fw_k2_empty", empty_f, 0);

        // ---------------- FWFT: continuous pop ----------------
        for (int i = 0; i < 7; i++) begin
            din_f = W'(i + 1);
            wr_f  = 1'b1;
            tick();
        end
        wr_f = 1'b0;
        check("fw_full", full_f, 1);
        check("fw_lvl8", lvl_f,  8);
        rd_f = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("fw_pop_valid", valid_f, 1);
            check("fw_pop_dout",  dout_f,  (i == 0) ? 32'h00A5 : i);
            check("fw_pop_lvl",   lvl_f,   8 - i);
            $display("fwft pop %0d data %h", i, dout_f);
            tick();
        end
        rd_f = 1'b0;
        check("fw_drain_valid", valid_f, 0);
        check("fw_drain_lvl",   lvl_f,   0);
        check("fw_drain_empty", empty_f, 1);
        rd_f = 1'b1;
        tick();
        rd_f = 1'b0;
        check("fw_udf", udf_f, 1);
        check("fw_udf_lvl", lvl_f, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
